// File: rtl/scoreboard_ctrl_pkg.sv
// Shared definitions for the scoreboard issue/read/write controller:
// per-FU state encoding, default sizing and default FU latencies.
package scoreboard_ctrl_pkg;

  typedef enum logic [1:0] {
    FU_IDLE     = 2'd0,
    FU_WAIT_OPS = 2'd1,
    FU_EXEC     = 2'd2,
    FU_WAIT_WB  = 2'd3
  } fu_state_t;

  localparam int DEF_NUM_FUS  = 4;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_REG_BITS = 5;
  localparam int DEF_FU_BITS  = 2;

  localparam int DEF_LAT0 = 1;
  localparam int DEF_LAT1 = 3;
  localparam int DEF_LAT2 = 8;
  localparam int DEF_LAT3 = 2;

  // Execute counters hold LAT-1, and LAT is at most 15.
  localparam int CNT_BITS = 4;

endpackage

// File: rtl/scoreboard_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// registered pointer; the pointer then moves one past the winner.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] win;
  logic [PW-1:0] idx;
  logic          found;

  // Scan requesters in circular order starting at the pointer.
  always_comb begin
    grant = '0;
    found = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr_q) + k) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win        = idx;
      end
    end
  end

  // Advance the priority pointer past the winner whenever a grant is given.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (found) begin
      ptr_q <= (win == PW'(N - 1)) ? '0 : win + PW'(1);
    end
  end

endmodule

// File: rtl/scoreboard_ctrl.sv
// Scoreboard controller: issue checks (structural, WAW, write-forward RAW),
// per-FU sequencing IDLE->WAIT_OPS->EXEC->WAIT_WB, round-robin operand-read
// and result-write arbitration with WAR protection, and a stall counter.
module scoreboard_ctrl
  import scoreboard_ctrl_pkg::*;
#(
  parameter int NUM_FUS  = DEF_NUM_FUS,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int REG_BITS = DEF_REG_BITS,
  parameter int FU_BITS  = DEF_FU_BITS,
  parameter int LAT0     = DEF_LAT0,
  parameter int LAT1     = DEF_LAT1,
  parameter int LAT2     = DEF_LAT2,
  parameter int LAT3     = DEF_LAT3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         instr_valid,
  output logic                         instr_ready,
  input  logic [FU_BITS-1:0]           instr_fu,
  input  logic [2:0]                   instr_op,
  input  logic [REG_BITS-1:0]          instr_fi,
  input  logic [REG_BITS-1:0]          instr_fj,
  input  logic [REG_BITS-1:0]          instr_fk,
  input  logic [NUM_FUS-1:0]           busy,
  input  logic [NUM_FUS-1:0]           rj,
  input  logic [NUM_FUS-1:0]           rk,
  input  logic [NUM_REGS*NUM_FUS-1:0]  reg_result_fu,
  output logic                         issue_grant,
  output logic [FU_BITS-1:0]           issue_fu,
  output logic [2:0]                   issue_op,
  output logic [REG_BITS-1:0]          issue_fi,
  output logic [REG_BITS-1:0]          issue_fj,
  output logic [REG_BITS-1:0]          issue_fk,
  output logic [NUM_FUS-1:0]           read_grant,
  output logic [NUM_FUS-1:0]           write_grant,
  output logic [NUM_FUS-1:0]           exec_start,
  output logic [15:0]                  stall_cnt
);

  function automatic int fu_lat(input int i);
    case (i)
      0:       return LAT0;
      1:       return LAT1;
      2:       return LAT2;
      default: return LAT3;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  fu_state_t           state_q [NUM_FUS];
  fu_state_t           state_d [NUM_FUS];
  logic [CNT_BITS-1:0] cnt_q   [NUM_FUS];
  logic [REG_BITS-1:0] fi_q    [NUM_FUS];
  logic [REG_BITS-1:0] fj_q    [NUM_FUS];
  logic [REG_BITS-1:0] fk_q    [NUM_FUS];

  logic [NUM_FUS-1:0]  rd_req, wr_req, rd_gnt, wr_gnt;
  logic                sel_idle, sel_busy, waw_hit, fwd_hazard, ready;
  logic [15:0]         stall_q;

  // Issue decision from registered FU state, the current write grant and the
  // status-table inputs; never depends on itself.
  always_comb begin
    sel_idle   = 1'b0;
    sel_busy   = 1'b0;
    waw_hit    = 1'b0;
    fwd_hazard = 1'b0;
    for (int i = 0; i < NUM_FUS; i++) begin
      if (instr_fu == FU_BITS'(i)) begin
        sel_idle = (state_q[i] == FU_IDLE);
        sel_busy = busy[i];
      end
      if (wr_gnt[i] &&
          ((instr_fj != '0 && instr_fj == fi_q[i]) ||
           (instr_fk != '0 && instr_fk == fi_q[i])))
        fwd_hazard = 1'b1;
    end
    for (int r = 1; r < NUM_REGS; r++) begin
      if (instr_fi == REG_BITS'(r))
        waw_hit = |reg_result_fu[r*NUM_FUS +: NUM_FUS];
    end
    ready = !rst && instr_valid && sel_idle && !sel_busy && !waw_hit && !fwd_hazard;
  end

  // Read requests need both operands; write requests are held while another
  // FU still has to read the old value of this FU's destination.
  always_comb begin
    rd_req = '0;
    wr_req = '0;
    for (int i = 0; i < NUM_FUS; i++) begin
      rd_req[i] = (state_q[i] == FU_WAIT_OPS) && rj[i] && rk[i];
      wr_req[i] = (state_q[i] == FU_WAIT_WB);
      for (int j = 0; j < NUM_FUS; j++) begin
        if (j != i && state_q[j] == FU_WAIT_OPS && fi_q[i] != '0 &&
            ((rj[j] && fj_q[j] == fi_q[i]) || (rk[j] && fk_q[j] == fi_q[i])))
          wr_req[i] = 1'b0;
      end
    end
  end

  rr_arbiter #(.N(NUM_FUS)) u_rd_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (rd_req),
    .grant (rd_gnt)
  );

  rr_arbiter #(.N(NUM_FUS)) u_wr_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (wr_req),
    .grant (wr_gnt)
  );

  assign instr_ready = ready;
  assign issue_grant = ready;
  assign issue_fu    = instr_fu;
  assign issue_op    = instr_op;
  assign issue_fi    = instr_fi;
  assign issue_fj    = instr_fj;
  assign issue_fk    = instr_fk;
  assign read_grant  = rst ? '0 : rd_gnt;
  assign write_grant = rst ? '0 : wr_gnt;
  assign exec_start  = rst ? '0 : rd_gnt;
  assign stall_cnt   = stall_q;

  // Per-FU next-state logic.
  always_comb begin
    for (int i = 0; i < NUM_FUS; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        FU_IDLE:     if (ready && instr_fu == FU_BITS'(i)) state_d[i] = FU_WAIT_OPS;
        FU_WAIT_OPS: if (rd_gnt[i])                        state_d[i] = FU_EXEC;
        FU_EXEC:     if (cnt_q[i] == '0)                   state_d[i] = FU_WAIT_WB;
        FU_WAIT_WB:  if (wr_gnt[i])                        state_d[i] = FU_IDLE;
        default:                                           state_d[i] = FU_IDLE;
      endcase
    end
  end

  // Per-FU state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_FUS; i++) state_q[i] <= FU_IDLE;
    end else begin
      for (int i = 0; i < NUM_FUS; i++) state_q[i] <= state_d[i];
    end
  end

  // Latch register indices at issue; load and run the execute countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_FUS; i++) begin
        cnt_q[i] <= '0;
        fi_q[i]  <= '0;
        fj_q[i]  <= '0;
        fk_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FUS; i++) begin
        if (ready && instr_fu == FU_BITS'(i)) begin
          fi_q[i] <= instr_fi;
          fj_q[i] <= instr_fj;
          fk_q[i] <= instr_fk;
        end
        if (rd_gnt[i])
          cnt_q[i] <= CNT_BITS'(fu_lat(i) - 1);
        else if (state_q[i] == FU_EXEC && cnt_q[i] != '0)
          cnt_q[i] <= cnt_q[i] - CNT_BITS'(1);
      end
    end
  end

  // Count cycles where an instruction is offered but not accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_q <= '0;
    else if (instr_valid && !ready)
      stall_q <= sat_inc16(stall_q);
  end

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Directed bench for scoreboard_ctrl; the bench plays the FU status table.
module tb_scoreboard_ctrl;

  localparam int NF = 4;
  localparam int NR = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             instr_valid;
  logic             instr_ready;
  logic [1:0]       instr_fu;
  logic [2:0]       instr_op;
  logic [4:0]       instr_fi, instr_fj, instr_fk;
  logic [NF-1:0]    busy, rj, rk;
  logic [NR*NF-1:0] reg_result_fu;
  logic             issue_grant;
  logic [1:0]       issue_fu;
  logic [2:0]       issue_op;
  logic [4:0]       issue_fi, issue_fj, issue_fk;
  logic [NF-1:0]    read_grant, write_grant, exec_start;
  logic [15:0]      stall_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  scoreboard_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_fu      (instr_fu),
    .instr_op      (instr_op),
    .instr_fi      (instr_fi),
    .instr_fj      (instr_fj),
    .instr_fk      (instr_fk),
    .busy          (busy),
    .rj            (rj),
    .rk            (rk),
    .reg_result_fu (reg_result_fu),
    .issue_grant   (issue_grant),
    .issue_fu      (issue_fu),
    .issue_op      (issue_op),
    .issue_fi      (issue_fi),
    .issue_fj      (issue_fj),
    .issue_fk      (issue_fk),
    .read_grant    (read_grant),
    .write_grant   (write_grant),
    .exec_start    (exec_start),
    .stall_cnt     (stall_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [1:0] fu, input logic [4:0] fi,
                         input logic [4:0] fj, input logic [4:0] fk);
    instr_valid = 1'b1;
    instr_fu    = fu;
    instr_op    = 3'd5;
    instr_fi    = fi;
    instr_fj    = fj;
    instr_fk    = fk;
  endtask

  task automatic set_res(input int r, input int f);
    reg_result_fu[r*NF +: NF] = 4'(1 << f);
  endtask

  task automatic clr_res(input int r);
    reg_result_fu[r*NF +: NF] = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0; instr_fu = '0; instr_op = '0;
    instr_fi = '0; instr_fj = '0; instr_fk = '0;
    busy = '0; rj = '0; rk = '0; reg_result_fu = '0;

    // Reset: outputs quiet even with a valid instruction offered.
    present(2'd0, 5'd1, 5'd2, 5'd3);
    #3;
    chk("rst_ready", instr_ready, 0);
    chk("rst_issue_grant", issue_grant, 0);
    chk("rst_read", read_grant, 0);
    chk("rst_write", write_grant, 0);
    chk("rst_stall", stall_cnt, 0);
    tick(); tick();
    rst = 1'b0; instr_valid = 1'b0;
    settle();
    chk("rel_read", read_grant, 0);

    // Independent ADD on FU0: r1 <- r2 + r3.
    tick(); present(2'd0, 5'd1, 5'd2, 5'd3); settle();
    chk("add_ready", instr_ready, 1);
    chk("add_issue_fu", issue_fu, 0);
    chk("add_issue_op", issue_op, 5);
    chk("add_issue_fi", issue_fi, 1);
    chk("add_issue_fj", issue_fj, 2);
    chk("add_issue_fk", issue_fk, 3);
    tick(); instr_valid = 1'b0; busy[0] = 1'b1; set_res(1, 0); rj[0] = 1'b1; rk[0] = 1'b1; settle();
    chk("add_read_c1", read_grant, 4'b0001);
    chk("add_exec_c1", exec_start, 4'b0001);
    tick(); rj[0] = 1'b0; rk[0] = 1'b0; settle();
    chk("add_read_c2", read_grant, 0);
    chk("add_exec_c2", exec_start, 0);
    chk("add_write_c2", write_grant, 0);
    tick(); present(2'd0, 5'd9, 5'd10, 5'd11); settle();
    chk("add_write_c3", write_grant, 4'b0001);
    chk("add_no_reissue", instr_ready, 0);
    tick(); instr_valid = 1'b0; busy[0] = 1'b0; clr_res(1); settle();
    chk("add_stall", stall_cnt, 1);
    chk("add_write_c4", write_grant, 0);

    // RAW: MUL FU1 r4 <- r5 + r6, then ADD FU0 r7 <- r4 + r2.
    tick(); present(2'd1, 5'd4, 5'd5, 5'd6); settle();
    chk("raw_mul_ready", instr_ready, 1);
    tick(); busy[1] = 1'b1; set_res(4, 1); rj[1] = 1'b1; rk[1] = 1'b1;
    present(2'd0, 5'd7, 5'd4, 5'd2); settle();
    chk("raw_add_ready", instr_ready, 1);
    chk("raw_mul_read", read_grant, 4'b0010);
    tick(); instr_valid = 1'b0; rj[1] = 1'b0; rk[1] = 1'b0;
    busy[0] = 1'b1; set_res(7, 0); rj[0] = 1'b0; rk[0] = 1'b1; settle();
    chk("raw_add_wait", read_grant, 0);
    tick(); tick(); settle();
    chk("raw_write_early", write_grant, 0);
    tick(); present(2'd2, 5'd12, 5'd4, 5'd0); settle();
    chk("raw_mul_write", write_grant, 4'b0010);
    chk("raw_read_held", read_grant, 0);
    chk("raw_fwd_block", instr_ready, 0);
    tick(); instr_valid = 1'b0; busy[1] = 1'b0; clr_res(4); rj[0] = 1'b1; settle();
    chk("raw_add_read", read_grant, 4'b0001);
    chk("raw_stall", stall_cnt, 2);
    tick(); rj[0] = 1'b0; rk[0] = 1'b0; settle();
    chk("raw_add_exec", write_grant, 0);
    tick(); settle();
    chk("raw_add_write", write_grant, 4'b0001);
    tick(); busy[0] = 1'b0; clr_res(7);

    // WAR: FU0 still to read r8 while FU3 produces r8.
    present(2'd0, 5'd9, 5'd8, 5'd10); settle();
    chk("war_fu0_ready", instr_ready, 1);
    tick(); busy[0] = 1'b1; set_res(9, 0); rj[0] = 1'b1; rk[0] = 1'b0;
    present(2'd3, 5'd8, 5'd1, 5'd2); settle();
    chk("war_fu3_ready", instr_ready, 1);
    chk("war_no_read", read_grant, 0);
    tick(); instr_valid = 1'b0; busy[3] = 1'b1; set_res(8, 3); rj[3] = 1'b1; rk[3] = 1'b1; settle();
    chk("war_fu3_read", read_grant, 4'b1000);
    tick(); rj[3] = 1'b0; rk[3] = 1'b0;
    tick();
    tick(); settle();
    chk("war_hold_1", write_grant, 0);
    tick(); rk[0] = 1'b1; settle();
    chk("war_fu0_read", read_grant, 4'b0001);
    chk("war_hold_2", write_grant, 0);
    tick(); rj[0] = 1'b0; rk[0] = 1'b0; settle();
    chk("war_fu3_write", write_grant, 4'b1000);
    tick(); busy[3] = 1'b0; clr_res(8); settle();
    chk("war_fu0_write", write_grant, 4'b0001);
    tick(); busy[0] = 1'b0; clr_res(9);

    // Contention: FU3 and FU0 request read, then write, together.
    present(2'd3, 5'd20, 5'd21, 5'd22); settle();
    chk("cont_fu3_ready", instr_ready, 1);
    tick(); busy[3] = 1'b1; set_res(20, 3); present(2'd0, 5'd23, 5'd24, 5'd25); settle();
    chk("cont_fu0_ready", instr_ready, 1);
    tick(); instr_valid = 1'b0; busy[0] = 1'b1; set_res(23, 0);
    rj[0] = 1'b1; rk[0] = 1'b1; rj[3] = 1'b1; rk[3] = 1'b1; settle();
    chk("cont_read_1", read_grant, 4'b1000);
    tick(); rj[3] = 1'b0; rk[3] = 1'b0; settle();
    chk("cont_read_2", read_grant, 4'b0001);
    chk("cont_exec_2", exec_start, 4'b0001);
    tick(); rj[0] = 1'b0; rk[0] = 1'b0; settle();
    chk("cont_write_0", write_grant, 0);
    tick(); settle();
    chk("cont_write_1", write_grant, 4'b1000);
    tick(); busy[3] = 1'b0; clr_res(20); settle();
    chk("cont_write_2", write_grant, 4'b0001);
    tick(); busy[0] = 1'b0; clr_res(23);

    // WAW: FU1 will write r4, FU2 wants r4 as destination.
    present(2'd1, 5'd4, 5'd5, 5'd6); settle();
    chk("waw_fu1_ready", instr_ready, 1);
    tick(); busy[1] = 1'b1; set_res(4, 1); rj[1] = 1'b1; rk[1] = 1'b1;
    present(2'd2, 5'd4, 5'd1, 5'd2); settle();
    chk("waw_block_1", instr_ready, 0);
    chk("waw_fu1_read", read_grant, 4'b0010);
    tick(); rj[1] = 1'b0; rk[1] = 1'b0; settle();
    chk("waw_block_2", instr_ready, 0);
    tick(); tick(); tick(); settle();
    chk("waw_fu1_write", write_grant, 4'b0010);
    chk("waw_block_wb", instr_ready, 0);
    tick(); busy[1] = 1'b0; clr_res(4); settle();
    chk("waw_release", instr_ready, 1);
    chk("waw_stall", stall_cnt, 7);
    tick(); instr_valid = 1'b0; busy[2] = 1'b1; set_res(4, 2); rj[2] = 1'b1; rk[2] = 1'b1; settle();
    chk("waw_fu2_read", read_grant, 4'b0100);
    chk("waw_fu2_exec", exec_start, 4'b0100);

    // Reset while FU2 executes.
    tick(); rst = 1'b1;
    busy = '0; reg_result_fu = '0; rj = '1; rk = '1;
    present(2'd0, 5'd1, 5'd2, 5'd3); settle();
    chk("mid_rst_read", read_grant, 0);
    chk("mid_rst_write", write_grant, 0);
    chk("mid_rst_exec", exec_start, 0);
    chk("mid_rst_ready", instr_ready, 0);
    chk("mid_rst_stall", stall_cnt, 0);
    tick(); tick();
    rst = 1'b0; instr_valid = 1'b0; settle();
    chk("post_rst_read", read_grant, 0);
    chk("post_rst_write", write_grant, 0);
    tick(); present(2'd2, 5'd4, 5'd5, 5'd6); settle();
    chk("post_rst_issue", instr_ready, 1);
    tick(); instr_valid = 1'b0; busy[2] = 1'b1; set_res(4, 2); settle();
    chk("post_rst_fu2_read", read_grant, 4'b0100);
    repeat (8) tick();
    settle();
    chk("post_rst_lat8_early", write_grant, 0);
    tick(); settle();
    chk("post_rst_lat8_write", write_grant, 4'b0100);
    chk("post_rst_stall", stall_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scoreboard_ctrl.md
SCOREBOARD_CTRL -- requirements
Module: scoreboard_ctrl

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- NUM_FUS, 4, functional units
- NUM_REGS, 32, architectural registers
- REG_BITS, 5, register index width
- FU_BITS, 2, FU index width
- LAT0..LAT3, 1/3/8/2, execute cycles per FU, each 1..15
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  decoded instruction present
- instr_ready  out  1  instruction issues this cycle
- instr_fu  in  FU_BITS  target FU
- instr_op  in  3  operation
- instr_fi  in  REG_BITS  destination
- instr_fj  in  REG_BITS  source 1
- instr_fk  in  REG_BITS  source 2
- busy  in  NUM_FUS  from FU status table
- rj  in  NUM_FUS  from FU status table
- rk  in  NUM_FUS  from FU status table
- reg_result_fu  in  NUM_REGS*NUM_FUS  one-hot producer per register
- issue_grant  out  1  to table
- issue_fu  out  FU_BITS  to table
- issue_op  out  3  to table
- issue_fi  out  REG_BITS  to table
- issue_fj  out  REG_BITS  to table
- issue_fk  out  REG_BITS  to table
- read_grant  out  NUM_FUS  operand read, at most one hot
- write_grant  out  NUM_FUS  result write, at most one hot
- exec_start  out  NUM_FUS  one-cycle pulse, FU begins execute
- stall_cnt  out  16  saturating count of valid-but-not-issued cycles

Function
REQ-003 Each FU SHALL run its own FSM with states IDLE, WAIT_OPS, EXEC, WAIT_WB.
REQ-004 instr_ready SHALL be combinational and high only when all of the following hold:
- instr_valid=1
- FSM[instr_fu]=IDLE
- busy[instr_fu]=0
- no WAW: instr_fi=0, or reg_result_fu field for instr_fi is zero
- no same-cycle write_grant whose destination equals a nonzero instr_fj or instr_fk
REQ-005 issue_grant SHALL equal instr_ready; the issue_* outputs SHALL pass instr_* through unchanged.
REQ-006 On issue, the FSM SHALL go IDLE->WAIT_OPS and latch fi, fj and fk locally for the WAR check.
REQ-007 Read request: an FU in WAIT_OPS with rj[i]&rk[i]=1 SHALL request a read.
REQ-008 One round-robin arbiter SHALL grant one read request per cycle; the pointer SHALL advance past the winner.
REQ-009 On read_grant[i], FU i SHALL go to EXEC, pulse exec_start[i] in that same cycle, and load its counter with LATi-1.
REQ-010 In EXEC the counter SHALL decrement every cycle; the FU SHALL go to WAIT_WB on the edge where the counter is 0. LAT=1 therefore spends exactly one cycle in EXEC.
REQ-011 Write request: an FU in WAIT_WB SHALL request a write only if no other FU in WAIT_OPS has either of these with the same nonzero register as its latched fi:
- fj equal to that fi with rj=1
- fk equal to that fi with rk=1
REQ-012 A second round-robin arbiter SHALL grant one write request per cycle; on write_grant[i], FU i SHALL return to IDLE.
REQ-013 An FU SHALL NOT be reissued in the cycle its write_grant is asserted, because busy is still 1 in that cycle.
REQ-014 Simultaneous issue, read and write in one cycle to different FUs SHALL all be permitted.
REQ-015 stall_cnt SHALL increment when instr_valid&!instr_ready and SHALL saturate at 0xFFFF.
REQ-016 All grant outputs SHALL be functions of registered state and the current inputs only, with no combinational loop through instr_ready.

Reset
REQ-017 While rst=1, the block SHALL immediately, without waiting for a clock edge:
- put all FSMs in IDLE
- clear counters, latched registers, arbiter pointers and stall_cnt
- drive instr_ready, issue_grant, read_grant, write_grant and exec_start to 0
REQ-018 Reset asserted mid-operation SHALL abandon all in-flight instructions; no grant SHALL appear in the first cycle after release.

Structure
REQ-019 A shared package SHALL hold:
- FSM state encoding
- default NUM_FUS, NUM_REGS, REG_BITS, FU_BITS
- default latency constants
REQ-020 A parameterised sub-module rr_arbiter (request vector in, one-hot grant out, registered pointer) SHALL be instantiated twice, once for reads and once for writes.

Verification
REQ-021 Directed scenarios:
- Independent ADD to FU0, r1<-r2+r3, all registers free -> issue in cycle 0; read_grant=0001 in cycle 1; exec_start[0] in cycle 1; write_grant=0001 in cycle 3.
- RAW: MUL to FU1 r4<-r5+r6, then ADD to FU0 r7<-r4+r2 -> FU0 read_grant only in the cycle after write_grant[1].
- WAW: FU1 writing r4, new instruction with fi=4 to FU2 -> instr_ready=0 and stall_cnt increments until write_grant[1].
- WAR: FU0 waiting to read r8, FU3 finished with fi=8 -> write_grant[3] held until read_grant[0].
- Contention: FU0 and FU3 both in WAIT_WB in the same cycle -> grants in consecutive cycles, rotating priority on repeat.
- rst pulsed while FU2 in EXEC -> all grants 0 and FSMs IDLE; a new instruction issues cleanly after release.
